// File: rtl/osd_spi_master.sv
// rtl/osd_spi_master.sv - SPI initiator driving the OSD sck/ss/sdi command port
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   cmd_valid/cmd_ready request handshake; cmd_op/cmd_line latched on accept
//   data_addr/data_in   payload fetch from caller-owned byte RAM (>=1 clk latency)
//   busy, done          frame in progress / one-clk pulse when ss rises
//   sck, ss, sdo        SPI clock (idle low), active-low select, MSB-first data
module osd_spi_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_line,
  output logic [7:0] data_addr,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       ss,
  output logic       sdo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP,
    S_DROP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [8:0] byte_q, byte_d;
  logic [1:0] op_q, op_d;
  logic [2:0] line_q, line_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_addr_q, data_addr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       sck_q, sck_d;
  logic       ss_q, ss_d;
  logic       cmd_ready_q, cmd_ready_d;

  logic [7:0] cmd_byte;
  logic [8:0] last_byte;
  logic       div_end;
  logic [7:0] div_next;

  always_comb begin
    case (op_q)
      2'd0:    cmd_byte = 8'h40;
      2'd1:    cmd_byte = 8'h41;
      default: cmd_byte = {5'b00100, line_q};
    endcase
    // A line write carries the command plus 256 payload bytes.
    last_byte = (op_q == 2'd2) ? 9'd256 : 9'd0;
    div_end   = (div_q == DIV_LAST);
    div_next  = div_end ? 8'd0 : div_q + 8'd1;
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    op_d        = op_q;
    line_d      = line_q;
    shreg_d     = shreg_q;
    data_addr_d = data_addr_q;
    done_d      = 1'b0;
    sck_d       = sck_q;
    ss_d        = ss_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d    = cmd_op;
          line_d  = cmd_line;
          state_d = S_START;
        end
      end
      S_START: begin
        if (op_q == 2'd3) begin
          // Reserved op: swallowed without touching the SPI pins.
          done_d  = 1'b1;
          state_d = S_DROP;
        end else begin
          ss_d        = 1'b0;
          sck_d       = 1'b0;
          shreg_d     = cmd_byte;
          bit_d       = 3'd0;
          byte_d      = 9'd0;
          data_addr_d = 8'd0;
          div_d       = 8'd0;
          state_d     = S_SETUP;
        end
      end
      S_SETUP, S_LOW: begin
        div_d = div_next;
        if (div_end) begin
          sck_d   = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        div_d = div_next;
        if (div_end) begin
          sck_d = 1'b0;
          if (bit_q == 3'd7 && byte_q == last_byte) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_LOW;
            if (bit_q == 3'd7) begin
              // Byte boundary: next byte comes straight from the RAM so ss never breaks.
              shreg_d = data_in;
              bit_d   = 3'd0;
              byte_d  = byte_q + 9'd1;
            end else begin
              shreg_d = {shreg_q[6:0], 1'b0};
              bit_d   = bit_q + 3'd1;
              // Prefetch the following payload byte early in the current one.
              if (bit_q == 3'd0 && byte_q != 9'd0) begin
                data_addr_d = (byte_q == 9'd256) ? 8'hFF : byte_q[7:0];
              end
            end
          end
        end
      end
      S_HOLD: begin
        div_d = div_next;
        if (div_end) begin
          ss_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        div_d = div_next;
        if (div_end) begin
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= 8'd0;
      bit_q       <= 3'd0;
      byte_q      <= 9'd0;
      op_q        <= 2'd0;
      line_q      <= 3'd0;
      shreg_q     <= 8'd0;
      data_addr_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sck_q       <= 1'b0;
      ss_q        <= 1'b1;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      op_q        <= op_d;
      line_q      <= line_d;
      shreg_q     <= shreg_d;
      data_addr_q <= data_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sck_q       <= sck_d;
      ss_q        <= ss_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign data_addr = data_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sck       = sck_q;
  assign ss        = ss_q;
  assign sdo       = shreg_q[7];

endmodule

// File: tb/tb_osd_spi_master.sv
// tb/tb_osd_spi_master.sv - self-checking bench for osd_spi_master (CLK_DIV 2 and 5)
module tb_osd_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [1:0]      cmd_valid_v, cmd_ready_v, busy_v, done_v, sck_v, ss_v, sdo_v;
  logic [1:0][1:0] cmd_op_v;
  logic [1:0][2:0] cmd_line_v;
  logic [1:0][7:0] data_addr_v, data_in_v;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    osd_spi_master #(.CLK_DIV(g == 0 ? 2 : 5)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid_v[g]),
      .cmd_ready (cmd_ready_v[g]),
      .cmd_op    (cmd_op_v[g]),
      .cmd_line  (cmd_line_v[g]),
      .data_addr (data_addr_v[g]),
      .data_in   (data_in_v[g]),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .sck       (sck_v[g]),
      .ss        (ss_v[g]),
      .sdo       (sdo_v[g])
    );
  end

  logic [7:0] ram [2][256];
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) data_in_v[g] <= ram[g][data_addr_v[g]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int acc_cyc[2], acc_cnt[2], ss_fall[2], ss_rise[2], first_rise[2], last_rise[2];
  int nrise[2], run[2], phase_bad[2], sdo_bad[2], done_cyc[2], done_cnt[2];
  int ready_cyc[2], ss_tog[2], sck_tog[2], frames[2];
  logic [7:0] cap [2][257];
  logic [7:0] osd_buf [2][2048];
  logic osd_en[2];
  logic ss_p[2], sck_p[2], sdo_p[2], rdy_p[2];
  int acc_log[$];
  int frame_log[$];

  function automatic int hdiv(input int g);
    return (g == 0) ? 2 : 5;
  endfunction

  function automatic int cmd_of(input int op, input int line);
    if (op == 0) return 'h40;
    if (op == 1) return 'h41;
    return 'h20 + line;
  endfunction

  // Bus monitor plus OSD receiver: decodes whole frames on ss rising, discards partial ones.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (cmd_valid_v[g] && cmd_ready_v[g]) begin
        acc_cyc[g] = cyc + 1;
        acc_cnt[g]++;
        if (g == 0) acc_log.push_back(int'(cmd_op_v[g]));
      end
      if (ss_v[g] !== ss_p[g]) ss_tog[g]++;
      if (sck_v[g] !== sck_p[g]) sck_tog[g]++;
      if (!ss_v[g] && ss_p[g]) begin
        ss_fall[g] = cyc;
        nrise[g] = 0;
        run[g] = 1;
      end else if (!ss_v[g]) begin
        if (sck_v[g] == sck_p[g]) run[g]++;
        else begin
          if (run[g] != hdiv(g)) phase_bad[g]++;
          run[g] = 1;
        end
        if (sck_v[g] && !sck_p[g]) begin
          if (nrise[g] == 0) first_rise[g] = cyc;
          last_rise[g] = cyc;
          if (nrise[g] < 2056) cap[g][nrise[g] / 8] = {cap[g][nrise[g] / 8][6:0], sdo_v[g]};
          nrise[g]++;
        end
        if (sck_v[g] && sck_p[g] && sdo_v[g] !== sdo_p[g]) sdo_bad[g]++;
      end
      if (ss_v[g] && !ss_p[g]) begin
        ss_rise[g] = cyc;
        if (run[g] != hdiv(g)) phase_bad[g]++;
        if (nrise[g] >= 8 && nrise[g] % 8 == 0) begin
          if (nrise[g] == 8 && cap[g][0] == 8'h40) begin
            osd_en[g] = 1'b0;
            frames[g]++;
          end else if (nrise[g] == 8 && cap[g][0] == 8'h41) begin
            osd_en[g] = 1'b1;
            frames[g]++;
          end else if (nrise[g] == 2056 && cap[g][0][7:3] == 5'b00100) begin
            for (int i = 0; i < 256; i++) osd_buf[g][int'(cap[g][0][2:0]) * 256 + i] = cap[g][i + 1];
            frames[g]++;
          end
          if (g == 0) frame_log.push_back(int'(cap[g][0]));
        end
      end
      if (done_v[g] === 1'b1) begin
        done_cyc[g] = cyc;
        done_cnt[g]++;
      end
      if (cmd_ready_v[g] === 1'b1 && rdy_p[g] !== 1'b1) ready_cyc[g] = cyc;
      ss_p[g]  = ss_v[g];
      sck_p[g] = sck_v[g];
      sdo_p[g] = sdo_v[g];
      rdy_p[g] = cmd_ready_v[g];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input int g, input int op, input int line);
    int a0;
    int n;
    a0 = acc_cnt[g];
    n = 0;
    cmd_valid_v[g] = 1'b1;
    cmd_op_v[g] = op[1:0];
    cmd_line_v[g] = line[2:0];
    while (acc_cnt[g] == a0 && n < 100) begin
      step();
      n++;
    end
    cmd_valid_v[g] = 1'b0;
    chk("accept", acc_cnt[g] - a0, 1);
  endtask

  task automatic wait_frame(input int g, input int budget);
    int d0;
    int n;
    d0 = done_cnt[g];
    n = 0;
    while (done_cnt[g] == d0 && n < budget) begin
      step();
      n++;
    end
    chk("frame_done", done_cnt[g] - d0, 1);
    n = 0;
    while (cmd_ready_v[g] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    step();
  endtask

  int t0, t1, t2, mis, line, op1, a1, sr1, rd1, la, lf;

  initial begin
    for (int g = 0; g < 2; g++) begin
      acc_cnt[g] = 0; nrise[g] = 0; run[g] = 0; phase_bad[g] = 0; sdo_bad[g] = 0;
      done_cnt[g] = 0; ss_tog[g] = 0; sck_tog[g] = 0; frames[g] = 0; osd_en[g] = 1'b0;
      ss_p[g] = 1'b1; sck_p[g] = 1'b0; sdo_p[g] = 1'b0; rdy_p[g] = 1'b1;
      for (int i = 0; i < 2048; i++) osd_buf[g][i] = 8'h00;
    end
    for (int i = 0; i < 256; i++) begin
      ram[0][i] = 8'(i) ^ 8'hA5;
      ram[1][i] = 8'($urandom_range(0, 255));
    end
    cmd_valid_v = '0;
    cmd_op_v = '0;
    cmd_line_v = '0;
    reset = 1'b1;
    repeat (3) step();

    chk("rst_cmd_ready", int'(cmd_ready_v[0]), 1);
    chk("rst_busy", int'(busy_v[0]), 0);
    chk("rst_done", int'(done_v[0]), 0);
    chk("rst_sck", int'(sck_v[0]), 0);
    chk("rst_ss", int'(ss_v[1]), 1);
    chk("rst_sdo", int'(sdo_v[0]), 0);
    chk("rst_data_addr", int'(data_addr_v[0]), 0);
    reset = 1'b0;
    repeat (2) step();

    issue(0, 1, 0);
    wait_frame(0, 100);
    chk("en_cmd", int'(cap[0][0]), 'h41);
    chk("en_bits", nrise[0], 8);
    chk("en_ss_fall", ss_fall[0] - acc_cyc[0], 1);
    chk("en_rise_first", first_rise[0] - acc_cyc[0], 3);
    chk("en_rise_last", last_rise[0] - acc_cyc[0], 31);
    chk("en_done", done_cyc[0] - acc_cyc[0], 35);
    chk("en_ready", ready_cyc[0] - acc_cyc[0], 37);
    chk("osd_enabled", int'(osd_en[0]), 1);

    issue(0, 0, 0);
    wait_frame(0, 100);
    chk("dis_cmd", int'(cap[0][0]), 'h40);
    chk("dis_done", done_cyc[0] - acc_cyc[0], 35);
    chk("dis_ready", ready_cyc[0] - acc_cyc[0], 37);
    chk("osd_disabled", int'(osd_en[0]), 0);

    t0 = ss_tog[0];
    issue(0, 2, 5);
    wait_frame(0, 9000);
    chk("wr_cmd", int'(cap[0][0]), 'h25);
    chk("wr_bits", nrise[0], 2056);
    chk("wr_ss_unbroken", ss_tog[0] - t0, 2);
    chk("wr_done", done_cyc[0] - acc_cyc[0], 1 + 4 * 2056 + 2);
    mis = 0;
    for (int i = 0; i < 256; i++) if (cap[0][i + 1] !== (8'(i) ^ 8'hA5)) mis++;
    chk("wr_payload", mis, 0);
    mis = 0;
    for (int i = 0; i < 256; i++) if (osd_buf[0][1280 + i] !== (8'(i) ^ 8'hA5)) mis++;
    chk("wr_osd_buffer", mis, 0);
    chk("h2_sdo_stable", sdo_bad[0], 0);
    chk("h2_phase_len", phase_bad[0], 0);

    t0 = sck_tog[0];
    t1 = ss_tog[0];
    t2 = done_cnt[0];
    issue(0, 3, 0);
    repeat (4) step();
    chk("rsv_done_cnt", done_cnt[0] - t2, 1);
    chk("rsv_done", done_cyc[0] - acc_cyc[0], 1);
    chk("rsv_ready", ready_cyc[0] - acc_cyc[0], 2);
    chk("rsv_sck_quiet", sck_tog[0] - t0, 0);
    chk("rsv_ss_quiet", ss_tog[0] - t1, 0);

    // Back-to-back with cmd_op churning while the first frame runs.
    la = acc_log.size();
    lf = frame_log.size();
    op1 = $urandom_range(0, 1);
    t0 = acc_cnt[0];
    cmd_valid_v[0] = 1'b1;
    cmd_op_v[0] = op1[1:0];
    for (int n = 0; n < 200 && acc_cnt[0] - t0 < 2; n++) begin
      step();
      if (acc_cnt[0] - t0 == 1) cmd_op_v[0] = 2'($urandom_range(0, 1));
    end
    cmd_valid_v[0] = 1'b0;
    chk("b2b_accepts", acc_cnt[0] - t0, 2);
    sr1 = ss_rise[0];
    rd1 = ready_cyc[0];
    a1 = acc_cyc[0];
    chk("b2b_gap_phase", rd1 - sr1, 2);
    chk("b2b_start", a1 - rd1, 1);
    wait_frame(0, 100);
    chk("b2b_ss_fall", ss_fall[0] - a1, 1);
    chk("b2b_frames", frame_log.size() - lf, 2);
    if (frame_log.size() - lf == 2 && acc_log.size() - la == 2) begin
      chk("b2b_cmd1", frame_log[lf], cmd_of(acc_log[la], 0));
      chk("b2b_cmd2", frame_log[lf + 1], cmd_of(acc_log[la + 1], 0));
    end

    line = $urandom_range(0, 7);
    issue(0, 2, line);
    for (int n = 0; n < 5000 && nrise[0] < 803; n++) step();
    chk("rst_mid_reached", int'(nrise[0] >= 803), 1);
    t0 = frames[0];
    t1 = done_cnt[0];
    reset = 1'b1;
    step();
    chk("mid_rst_ss", int'(ss_v[0]), 1);
    chk("mid_rst_sck", int'(sck_v[0]), 0);
    chk("mid_rst_busy", int'(busy_v[0]), 0);
    chk("mid_rst_addr", int'(data_addr_v[0]), 0);
    chk("mid_rst_done", int'(done_v[0]), 0);
    reset = 1'b0;
    repeat (10) step();
    chk("mid_rst_no_done", done_cnt[0] - t1, 0);
    chk("mid_rst_discarded", frames[0] - t0, 0);
    issue(0, 1, 0);
    wait_frame(0, 100);
    chk("post_rst_done", done_cyc[0] - acc_cyc[0], 35);
    chk("post_rst_osd_en", int'(osd_en[0]), 1);

    issue(1, 1, 0);
    wait_frame(1, 200);
    chk("h5_en_done", done_cyc[1] - acc_cyc[1], 1 + 2 * 5 * 8 + 5);
    chk("h5_en_ready", ready_cyc[1] - acc_cyc[1], 1 + 2 * 5 * 8 + 10);
    line = $urandom_range(0, 7);
    issue(1, 2, line);
    wait_frame(1, 25000);
    chk("h5_cmd", int'(cap[1][0]), cmd_of(2, line));
    chk("h5_bits", nrise[1], 2056);
    chk("h5_rise_first", first_rise[1] - acc_cyc[1], 6);
    chk("h5_done", done_cyc[1] - acc_cyc[1], 1 + 2 * 5 * 2056 + 5);
    mis = 0;
    for (int i = 0; i < 256; i++) if (cap[1][i + 1] !== ram[1][i]) mis++;
    chk("h5_payload", mis, 0);
    mis = 0;
    for (int i = 0; i < 256; i++) if (osd_buf[1][line * 256 + i] !== ram[1][i]) mis++;
    chk("h5_osd_buffer", mis, 0);
    chk("h5_phase_len", phase_bad[1], 0);
    chk("h5_sdo_stable", sdo_bad[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
